// File: rtl/simon_pkg.sv
// Shared codes for the Simon game blocks.
// Flash, input checker and message blocks all use these.
package simon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE,
    WIN,
    LOSE
  } state_t;

  localparam logic [1:0] LED_OFF   = 2'b00;
  localparam logic [1:0] LED_RIGHT = 2'b01;
  localparam logic [1:0] LED_LEFT  = 2'b10;

  localparam logic RESULT_WIN  = 1'b1;
  localparam logic RESULT_LOSE = 1'b0;

  function automatic logic [1:0] led_code(
    input logic right
  );
    return right ? LED_RIGHT : LED_LEFT;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchronizer plus stable-level debounce.
// btn_press pulses for one cycle on each accepted rising edge.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], btn_raw};
      r_press <= 1'b0;
      // count only while the synced input disagrees with the level
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_level <= r_sync[1];
        r_press <= r_sync[1];
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign btn_level = r_level;
  assign btn_press = r_press;

endmodule

// File: rtl/simon_input_checker.sv
// Captures left/right presses and checks them against bit_gen.
// Produces the win/lose verdict and a press echo on the LEDs.
module simon_input_checker
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TIMEOUT_CYCLES  = 500_000_000,
  parameter int ECHO_CYCLES     = 25_000_000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [2:0] bit_count,
  input  logic [7:0] bit_gen,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [1:0] led_echo,
  output logic [3:0] input_index,
  output logic       check_done,
  output logic       result
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int EW = $clog2(ECHO_CYCLES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [EW-1:0] E_LAST = EW'(ECHO_CYCLES - 1);

  logic w_lvl_l, w_lvl_r;
  logic w_prs_l, w_prs_r;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_left (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_raw  (btn_left),
    .btn_level(w_lvl_l),
    .btn_press(w_prs_l)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_right (
    .clock    (clock),
    .reset_n  (reset_n),
    .btn_raw  (btn_right),
    .btn_level(w_lvl_r),
    .btn_press(w_prs_r)
  );

  state_t        r_state;
  logic [3:0]    r_idx;
  logic [TW-1:0] r_tmo;
  logic          r_done;
  logic          r_res;
  logic [1:0]    r_led;
  logic [EW-1:0] r_ecnt;

  logic w_single;
  logic w_clash;
  logic w_exp;
  logic w_good;
  logic w_any;
  logic w_tmo_hit;
  logic w_released;
  logic w_seq_done;

  assign w_single   = w_prs_l ^ w_prs_r;
  assign w_clash    = (w_prs_l & w_lvl_r)
                    | (w_prs_r & w_lvl_l);
  assign w_exp      = bit_gen[r_idx[2:0]];
  assign w_good     = w_single & ~w_clash
                    & (w_prs_r == w_exp);
  assign w_any      = w_prs_l | w_prs_r;
  assign w_tmo_hit  = (r_tmo == T_LAST);
  assign w_released = ~w_lvl_l & ~w_lvl_r;
  assign w_seq_done = r_idx > {1'b0, bit_count};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_tmo   <= '0;
      r_done  <= 1'b0;
      r_res   <= RESULT_LOSE;
    end else if (!enable) begin
      r_state <= IDLE;
      r_idx   <= 4'd0;
      r_tmo   <= '0;
      r_done  <= 1'b0;
      r_res   <= RESULT_LOSE;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_idx   <= 4'd0;
          r_tmo   <= '0;
          r_state <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (w_good) begin
            r_idx   <= r_idx + 4'd1;
            r_tmo   <= '0;
            r_state <= WAIT_RELEASE;
          end else if (w_any || w_tmo_hit) begin
            r_state <= LOSE;
            r_done  <= 1'b1;
            r_res   <= RESULT_LOSE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        WAIT_RELEASE: begin
          if (w_tmo_hit) begin
            r_state <= LOSE;
            r_done  <= 1'b1;
            r_res   <= RESULT_LOSE;
          end else begin
            r_tmo <= r_tmo + TW'(1);
            if (w_released && w_seq_done) begin
              r_state <= WIN;
              r_done  <= 1'b1;
              r_res   <= RESULT_WIN;
            end else if (w_released) begin
              r_state <= WAIT_PRESS;
            end
          end
        end
        WIN, LOSE: begin
          r_state <= r_state;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // echo shows any single press seen while waiting, right or wrong
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_led  <= LED_OFF;
      r_ecnt <= '0;
    end else if (!enable) begin
      r_led  <= LED_OFF;
      r_ecnt <= '0;
    end else if (r_state == WAIT_PRESS && w_single) begin
      r_led  <= led_code(w_prs_r);
      r_ecnt <= E_LAST;
    end else if (r_ecnt != '0) begin
      r_ecnt <= r_ecnt - EW'(1);
    end else begin
      r_led <= LED_OFF;
    end
  end

  assign led_echo    = r_led;
  assign input_index = r_idx;
  assign check_done  = r_done;
  assign result      = r_res;

endmodule

// File: tb/tb_simon_input_checker.sv
// Directed vector bench for simon_input_checker.
// Small parameters keep every scenario to a few hundred cycles.
module tb_simon_input_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] bc;
  logic [7:0] bg;
  logic       bl, br;
  logic [1:0] led_echo;
  logic [3:0] input_index;
  logic       check_done;
  logic       result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  simon_input_checker #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (200),
    .ECHO_CYCLES    (8)
  ) dut (
    .clock      (clk),
    .reset_n    (rst_n),
    .enable     (en),
    .bit_count  (bc),
    .bit_gen    (bg),
    .btn_left   (bl),
    .btn_right  (br),
    .led_echo   (led_echo),
    .input_index(input_index),
    .check_done (check_done),
    .result     (result)
  );

  typedef struct {
    string      tag;
    logic       en, bl, br;
    logic [2:0] bc;
    logic [7:0] bg;
    int         n;
    logic [3:0] idx;
    logic       done, res;
    logic [1:0] led;
  } vec_t;

  vec_t q[$];

  function automatic void add(
    input string tag,
    input logic e, input logic l, input logic r,
    input logic [2:0] c, input logic [7:0] g,
    input int n,
    input logic [3:0] idx, input logic d,
    input logic rs, input logic [1:0] led
  );
    vec_t v;
    v.tag = tag; v.en = e; v.bl = l; v.br = r;
    v.bc = c; v.bg = g; v.n = n;
    v.idx = idx; v.done = d; v.res = rs; v.led = led;
    q.push_back(v);
  endfunction

  task automatic check(
    input string tag, input logic [3:0] ei,
    input logic ed, input logic er, input logic [1:0] el
  );
    n_vec++;
    if ({input_index, check_done, result, led_echo}
        !== {ei, ed, er, el}) begin
      n_err++;
      $display("FAIL %s: got idx=%0d done=%b res=%b led=%b, want idx=%0d done=%b res=%b led=%b",
               tag, input_index, check_done, result, led_echo,
               ei, ed, er, el);
    end
  endtask

  task automatic check_val(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, want);
    end
  endtask

  // Inputs change on a falling edge; outputs are checked n falling edges later.
  task automatic run_rows();
    foreach (q[i]) begin
      en = q[i].en; bl = q[i].bl; br = q[i].br;
      bc = q[i].bc; bg = q[i].bg;
      repeat (q[i].n) @(negedge clk);
      check(q[i].tag, q[i].idx, q[i].done, q[i].res, q[i].led);
    end
    q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [7:0] G = 8'b0000_0101;

  initial begin
    int  n;
    bit  seen;
    rst_n = 1'b0; en = 1'b0; bl = 1'b0; br = 1'b0;
    bc = 3'd0; bg = 8'd0;
    #1;
    check("reset_async", 0, 0, 0, 2'b00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Winning sequence R, L, R
    add("idle",      0,0,0, 2,G, 2,  0,0,0,2'b00);
    add("start",     1,0,0, 2,G, 3,  0,0,0,2'b00);
    add("r1_pend",   1,0,1, 2,G, 6,  0,0,0,2'b00);
    add("r1_acc",    1,0,1, 2,G, 1,  1,0,0,2'b01);
    add("r1_hold",   1,0,1, 2,G, 3,  1,0,0,2'b01);
    add("r1_rel",    1,0,0, 2,G, 4,  1,0,0,2'b01);
    add("r1_echoff", 1,0,0, 2,G, 1,  1,0,0,2'b00);
    add("r1_gap",    1,0,0, 2,G, 5,  1,0,0,2'b00);
    add("l2_pend",   1,1,0, 2,G, 6,  1,0,0,2'b00);
    add("l2_acc",    1,1,0, 2,G, 1,  2,0,0,2'b10);
    add("l2_hold",   1,1,0, 2,G, 3,  2,0,0,2'b10);
    add("l2_rel",    1,0,0, 2,G, 4,  2,0,0,2'b10);
    add("l2_echoff", 1,0,0, 2,G, 1,  2,0,0,2'b00);
    add("l2_gap",    1,0,0, 2,G, 5,  2,0,0,2'b00);
    add("r3_pend",   1,0,1, 2,G, 6,  2,0,0,2'b00);
    add("r3_acc",    1,0,1, 2,G, 1,  3,0,0,2'b01);
    add("r3_hold",   1,0,1, 2,G, 3,  3,0,0,2'b01);
    add("r3_rel",    1,0,0, 2,G, 4,  3,0,0,2'b01);
    add("r3_echoff", 1,0,0, 2,G, 1,  3,0,0,2'b00);
    add("win",       1,0,0, 2,G, 5,  3,1,1,2'b00);
    add("win_clear", 0,0,0, 2,G, 1,  0,0,0,2'b00);

    // Wrong second press
    add("w_start",   1,0,0, 2,G, 3,  0,0,0,2'b00);
    add("w_r1_pend", 1,0,1, 2,G, 6,  0,0,0,2'b00);
    add("w_r1_acc",  1,0,1, 2,G, 1,  1,0,0,2'b01);
    add("w_r1_hold", 1,0,1, 2,G, 3,  1,0,0,2'b01);
    add("w_r1_rel",  1,0,0, 2,G, 10, 1,0,0,2'b00);
    add("w_r2_pend", 1,0,1, 2,G, 6,  1,0,0,2'b00);
    add("w_lose",    1,0,1, 2,G, 1,  1,1,0,2'b01);
    add("w_hold",    1,0,1, 2,G, 3,  1,1,0,2'b01);
    add("w_rel",     1,0,0, 2,G, 10, 1,1,0,2'b00);
    add("w_clear",   0,0,0, 2,G, 1,  0,0,0,2'b00);

    // Timeout with no presses
    add("t_before",  1,0,0, 0,8'h00, 195, 0,0,0,2'b00);
    add("t_lose",    1,0,0, 0,8'h00, 10,  0,1,0,2'b00);
    add("t_clear",   0,0,0, 0,8'h00, 1,   0,0,0,2'b00);

    // Both buttons at once, then left against a held right
    add("b_start",   1,0,0, 0,8'h00, 2,  0,0,0,2'b00);
    add("b_both",    1,1,1, 0,8'h00, 7,  0,1,0,2'b00);
    add("b_clear",   0,0,0, 0,8'h00, 10, 0,0,0,2'b00);
    add("h_rhold",   0,0,1, 0,8'h00, 10, 0,0,0,2'b00);
    add("h_start",   1,0,1, 0,8'h00, 2,  0,0,0,2'b00);
    add("h_left",    1,1,1, 0,8'h00, 7,  0,1,0,2'b10);
    add("h_clear",   0,0,0, 0,8'h00, 10, 0,0,0,2'b00);

    // Enable drop in WAIT_PRESS after two correct presses
    add("e_start",   1,0,0, 2,G, 2,  0,0,0,2'b00);
    add("e_r1",      1,0,1, 2,G, 7,  1,0,0,2'b01);
    add("e_r1_rel",  1,0,0, 2,G, 13, 1,0,0,2'b00);
    add("e_l2",      1,1,0, 2,G, 7,  2,0,0,2'b10);
    add("e_l2_rel",  1,0,0, 2,G, 13, 2,0,0,2'b00);
    add("e_drop",    0,0,0, 2,G, 1,  0,0,0,2'b00);
    add("x_start",   1,0,0, 2,G, 2,  0,0,0,2'b00);
    add("x_r1",      1,0,1, 2,G, 7,  1,0,0,2'b01);
    @(negedge clk);
    run_rows();

    // Asynchronous reset mid-sequence
    br = 1'b0;
    #2 rst_n = 1'b0;
    #1 check("reset_mid", 0, 0, 0, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (check_done || input_index != 0) seen = 1'b1;
    end
    check_val("no_verdict_after_reset", int'(seen), 0);

    // Bouncing left button, then a clean hold
    en = 1'b0;
    repeat (2) @(negedge clk);
    bc = 3'd1; bg = 8'h00; en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      bl = (i % 2 == 0);
      repeat (2) @(negedge clk);
    end
    check_val("bounce_no_press", int'(input_index), 0);
    bl = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (input_index != 4'd1 && n < 40);
    check_val("bounce_latency", n, 7);
    repeat (20) @(negedge clk);
    check("bounce_single", 1, 0, 0, 2'b00);
    bl = 1'b0;
    en = 1'b0;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/simon_input_checker.md
Name: simon_input_checker

Overview:
- Player-side counterpart of the LED flash sequencer: captures the player's left/right button presses and checks each against the generated bit pattern.
- Produces the win/lose `result` and a `check_done` pulse-level flag.
- These feed the 7-segment message block (`start`, `result`).
- Sits between the top-level button pins and the message display. It uses the same `bit_gen`/`bit_count` that drove the flash phase.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, stable-level cycles required before a button change is accepted (10 ms at 100 MHz).
- TIMEOUT_CYCLES, 500_000_000, max cycles allowed between accepted presses before automatic lose (5 s).
- ECHO_CYCLES, 25_000_000, cycles the echo LED stays lit after an accepted press.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  high = input phase active; low = idle/clear.
- bit_count  in  3  sequence length minus 1 (length 1..8).
- bit_gen  in  8  expected pattern; bit i is the i-th press (1 = right, 0 = left).
- btn_left  in  1  raw left pushbutton, asynchronous, active-high.
- btn_right  in  1  raw right pushbutton, asynchronous, active-high.
- led_echo  out  2  press feedback: 2'b10 = left, 2'b01 = right, 2'b00 = off.
- input_index  out  4  number of correct presses accepted so far (0..8).
- check_done  out  1  high while the verdict is valid.
- result  out  1  1 = win, 0 = lose; meaningful only when check_done = 1.

Behaviour:
- Reset (reset_n = 0, async):
  - state = IDLE.
  - led_echo = 2'b00, input_index = 0, check_done = 0, result = 0.
  - All counters = 0.
  - Synchronizer flops = 0.
- Button conditioning:
  - Each button passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized input has held its new level for DEBOUNCE_CYCLES consecutive cycles.
  - A press event is a 1-cycle pulse on the debounced rising edge.
  - Latency from a clean raw edge to the press pulse = 2 + DEBOUNCE_CYCLES cycles.
- enable = 0 (any state): next cycle state = IDLE.
  - Outputs return to their reset values.
  - Debouncers keep running so held buttons are tracked.
- States and transitions:
  - IDLE:
    - On enable = 1 → WAIT_PRESS.
    - input_index = 0, timeout counter = 0.
  - WAIT_PRESS:
    - Timeout counter increments each cycle.
    - If it reaches TIMEOUT_CYCLES-1 with no press → LOSE.
    - Left press alone: correct if bit_gen[input_index] == 0.
    - Right press alone: correct if bit_gen[input_index] == 1.
    - Correct press:
      - input_index += 1, timeout counter cleared.
      - Echo LED loaded for ECHO_CYCLES.
      - Next state: WAIT_RELEASE.
    - Wrong press → LOSE. Echo still shows the pressed side.
    - Both press pulses in the same cycle, or a press while the other debounced button is already high → LOSE.
  - WAIT_RELEASE:
    - Waits until both debounced levels are 0; no new presses are accepted while here.
    - Then, if input_index > bit_count → WIN, else → WAIT_PRESS.
    - The timeout counter also runs here; expiry → LOSE.
  - WIN:
    - check_done = 1, result = 1.
    - Held until enable = 0.
    - Further presses are ignored.
  - LOSE:
    - check_done = 1, result = 0.
    - Held until enable = 0.
- Echo:
  - led_echo is set on the cycle after an accepted press and stays set for exactly ECHO_CYCLES cycles, then returns to 2'b00.
  - It is independent of the state machine except for enable = 0 and reset.
  - A new press restarts the echo timer.
- Widths:
  - Comparison index uses input_index[2:0]; input_index never exceeds 8.
  - Counters are sized with $clog2 of their parameter and saturate; they never wrap.
- Mid-operation reset or enable drop: the in-progress sequence is abandoned. No verdict is produced.

Decomposition:
- Shared package `simon_pkg`:
  - state enum {IDLE, WAIT_PRESS, WAIT_RELEASE, WIN, LOSE}.
  - LED codes LED_OFF = 2'b00, LED_RIGHT = 2'b01, LED_LEFT = 2'b10.
  - RESULT_WIN = 1, RESULT_LOSE = 0.
  - The flash block and the message block reuse these codes.
- One sub-module: `button_debouncer`.
  - Ports: clock, reset_n, btn_raw, btn_level, btn_press.
  - Parameter: DEBOUNCE_CYCLES.
  - Instantiated twice.

Test Plan (DEBOUNCE_CYCLES = 4, TIMEOUT_CYCLES = 200, ECHO_CYCLES = 8):
- bit_gen = 8'b0000_0101, bit_count = 2; press right, left, right with clean edges, each held 10 cycles, gaps of 10 cycles → input_index = 1, 2, 3; check_done = 1, result = 1; led_echo = 01, 10, 01 respectively, each for 8 cycles.
- Same pattern; second press is right → state LOSE, check_done = 1, result = 0, input_index = 1.
- bit_count = 0, bit_gen[0] = 0; no press for 200 cycles after enable → check_done = 1, result = 0 at cycle 200 ±1.
- Raw left toggling every 2 cycles for 20 cycles, then held → exactly one press accepted, 6 cycles after the hold begins.
- Both buttons rise in the same cycle → LOSE; also right held while left pressed → LOSE.
- enable dropped during WAIT_PRESS with input_index = 2 → next cycle all outputs 0; a reset_n pulse mid-sequence clears outputs asynchronously, with no check_done pulse.
